frb_bram_writer: RTL

Write-side companion to the playback address counter. It accepts a stream of samples over a valid/ready handshake and keeps one of every DECIM accepted samples. Each kept sample is written into the waveform BRAM at sequential addresses 0 to 2^ADDR_SIZE-1. When the table is full it flags done, and the address counter can then replay the contents. It sits between the sample source (host loader or capture path) and the BRAM write port.

---
 rtl/frb_bram_writer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/frb_bram_writer.sv
// frb_bram_writer: decimating valid/ready sample stream to sequential BRAM table writer.
// Rev 1.0
`default_nettype none

module frb_bram_writer #(
   parameter int ADDR_SIZE  = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arm,
   input  logic                  abort,
   input  logic [31:0]           decimate,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [ADDR_SIZE-1:0]  bram_addr,
   output logic [DATA_WIDTH-1:0] bram_din,
   output logic                  bram_we,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_t;

   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

   state_t                state_q, state_d;
   logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
   logic [31:0]           dec_cnt_q, dec_cnt_d;
   logic [31:0]           dec_lat_q, dec_lat_d;
   logic [ADDR_SIZE-1:0]  bram_addr_q, bram_addr_d;
   logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
   logic                  bram_we_q, bram_we_d;
   logic                  done_q, done_d;
   logic                  accept;

   assign din_ready = (state_q == FILL);
   assign busy      = (state_q == FILL);
   assign accept    = din_valid && din_ready;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      dec_cnt_d   = dec_cnt_q;
      dec_lat_d   = dec_lat_q;
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
      bram_we_d   = 1'b0;
      done_d      = done_q;

      case (state_q)
         IDLE, FULL: begin
            if (arm) begin
               dec_lat_d = (decimate == 32'd0) ? 32'd1 : decimate;
               wr_ptr_d  = '0;
               dec_cnt_d = '0;
               done_d    = 1'b0;
               state_d   = FILL;
            end
         end
         FILL: begin
            if (accept) begin
               dec_cnt_d = (dec_cnt_q == dec_lat_q - 32'd1) ? 32'd0 : dec_cnt_q + 32'd1;
               if (dec_cnt_q == 32'd0) begin
                  bram_we_d   = 1'b1;
                  bram_addr_d = wr_ptr_q;
                  bram_din_d  = din;
                  wr_ptr_d    = wr_ptr_q + ADDR_SIZE'(1);
                  if (wr_ptr_q == LAST_ADDR) begin
                     state_d = FULL;
                     done_d  = 1'b1;
                  end
               end
            end
            // Abort overrides the FSM but a write captured this cycle still lands.
            if (abort) begin
               state_d   = IDLE;
               done_d    = 1'b0;
               wr_ptr_d  = '0;
               dec_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         dec_cnt_q   <= '0;
         dec_lat_q   <= 32'd1;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
         bram_we_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         dec_cnt_q   <= dec_cnt_d;
         dec_lat_q   <= dec_lat_d;
         bram_addr_q <= bram_addr_d;
         bram_din_q  <= bram_din_d;
         bram_we_q   <= bram_we_d;
         done_q      <= done_d;
      end
   end

   assign bram_addr = bram_addr_q;
   assign bram_din  = bram_din_q;
   assign bram_we   = bram_we_q;
   assign done      = done_q;

endmodule

`default_nettype wire
